// File: rtl/alu_pkg.sv
// Shared ALU constants: sel codes, ALUOp/funct encodings and the issue
// controller's FSM state encoding. Used by the ALU and its control logic.
package alu_pkg;

  // ALU sel codes
  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;
  localparam logic [2:0] SEL_NOR = 3'b100;

  // ALUOp codes from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // MIPS R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  // Issue controller FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALUOp/funct -> ALU sel decode with an error flag for
// reserved ALUOp values and unsupported funct codes.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] sel,
  output logic       err
);

  // Undecodable requests fall back to sel=AND with err raised
  always_comb begin
    sel = SEL_AND;
    err = 1'b1;
    case (aluop)
      ALUOP_ADD: begin
        sel = SEL_ADD;
        err = 1'b0;
      end
      ALUOP_SUB: begin
        sel = SEL_SUB;
        err = 1'b0;
      end
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: begin sel = SEL_ADD; err = 1'b0; end
          FUNCT_SUB: begin sel = SEL_SUB; err = 1'b0; end
          FUNCT_AND: begin sel = SEL_AND; err = 1'b0; end
          FUNCT_OR:  begin sel = SEL_OR;  err = 1'b0; end
          FUNCT_SLT: begin sel = SEL_SLT; err = 1'b0; end
          FUNCT_NOR: begin sel = SEL_NOR; err = 1'b0; end
          default: begin
            sel = SEL_AND;
            err = 1'b1;
          end
        endcase
      end
      ALUOP_RSVD: begin
        sel = SEL_AND;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencing front end for the combinational 32-bit ALU: accepts one
// request, drives registered operands/sel, captures the result one cycle
// later and returns it on a valid/ready response channel.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [2:0]       alu_sel,
  input  logic [31:0]      alu_result,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  logic [1:0] state;
  logic       err_q;
  logic [2:0] dec_sel;
  logic       dec_err;
  logic       accept;
  logic       exec;
  logic       done;

  alu_decode u_decode (
    .aluop (req_aluop),
    .funct (req_funct),
    .sel   (dec_sel),
    .err   (dec_err)
  );

  // Handshake outputs decode from state only; reset forces req_ready low
  assign req_ready = (state == ST_IDLE) && !rst;
  assign rsp_valid = (state == ST_RESP);

  assign accept = (state == ST_IDLE) && req_valid;
  assign exec   = (state == ST_EXEC);
  assign done   = (state == ST_RESP) && rsp_ready;

  // IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on consume
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) state <= ST_EXEC;
        ST_EXEC: state <= ST_RESP;
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand, sel and decode-error registers load only on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op1 <= '0;
      alu_op2 <= '0;
      alu_sel <= SEL_AND;
      err_q   <= 1'b0;
    end else if (accept) begin
      alu_op1 <= req_a;
      alu_op2 <= req_b;
      alu_sel <= dec_sel;
      err_q   <= dec_err;
    end
  end

  // Capture the settled ALU outputs in EXEC; errored requests return zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (exec) begin
      if (err_q) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b0;
        rsp_err    <= 1'b1;
      end else begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zf;
        rsp_err    <= 1'b0;
      end
    end
  end

  // Completed-response counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (done) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_aluop = 2'b00;
  logic [5:0]  req_funct = 6'b000000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] alu_op1, alu_op2;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_zf;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [1:0]  op_count;

  alu_issue_ctrl #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU (unsigned SLT, as the real ALU does)
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_op1 & alu_op2;
      3'b001:  alu_result = alu_op1 | alu_op2;
      3'b010:  alu_result = alu_op1 + alu_op2;
      3'b110:  alu_result = alu_op1 - alu_op2;
      3'b111:  alu_result = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
      3'b100:  alu_result = ~(alu_op1 | alu_op2);
      default: alu_result = '0;
    endcase
    alu_zf = (alu_result == 32'd0);
  end

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic cnt_pend = 1'b0;
  logic [1:0] cnt_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pop the scoreboard on every response handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      cnt_pend = 1'b0;
    end else begin
      if (cnt_pend) begin
        check("op_count", 32'(op_count), 32'(cnt_exp));
        cnt_pend = 1'b0;
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got result 0x%08h, expected no response", rsp_result);
        end else begin
          e = sbq.pop_front();
          check("rsp_result", rsp_result, e.res);
          check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("alu_sel", 32'(alu_sel), 32'(e.sel));
          cnt_pend = 1'b1;
          cnt_exp  = e.cnt;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: got 0, expected 1 within 40 cycles");
    end else begin
      sbq.push_back(e);
      req_valid = 1'b1;
      req_aluop = op;
      req_funct = fn;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      acc_cyc   = cyc;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || cnt_pend) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0 || cnt_pend) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev;
    int n;
    // Reset and idle
    repeat (2) begin
      @(posedge clk);
      #1;
      check("ready_in_rst", 32'(req_ready), 32'd0);
    end
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_op1", alu_op1, 32'd0);
    check("rst_op2", alu_op2, 32'd0);
    check("rst_sel", 32'(alu_sel), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // SLT with latency check
    issue(ALUOP_RTYPE, FUNCT_SLT, 32'd5, 32'd7, exp_t'{SEL_SLT, 32'd1, 1'b0, 1'b0, 2'd1});
    check("lat_exec_valid", 32'(rsp_valid), 32'd0);
    check("lat_exec_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("lat_resp_valid", 32'(rsp_valid), 32'd1);
    drain();

    issue(ALUOP_SUB, 6'b101010, 32'h1234, 32'h1234, exp_t'{SEL_SUB, 32'd0, 1'b1, 1'b0, 2'd2});
    issue(ALUOP_RTYPE, FUNCT_NOR, 32'hFFFF0000, 32'h0000FF00, exp_t'{SEL_NOR, 32'h000000FF, 1'b0, 1'b0, 2'd3});
    issue(ALUOP_RTYPE, 6'b000000, 32'hFFFFFFFF, 32'hFFFFFFFF, exp_t'{SEL_AND, 32'd0, 1'b0, 1'b1, 2'd0});
    issue(ALUOP_RSVD, FUNCT_ADD, 32'd1, 32'd1, exp_t'{SEL_AND, 32'd0, 1'b0, 1'b1, 2'd1});
    issue(ALUOP_RTYPE, FUNCT_ADD, 32'd3, 32'd4, exp_t'{SEL_ADD, 32'd7, 1'b0, 1'b0, 2'd2});
    issue(ALUOP_RTYPE, FUNCT_AND, 32'hF0F0, 32'hFF00, exp_t'{SEL_AND, 32'hF000, 1'b0, 1'b0, 2'd3});
    issue(ALUOP_RTYPE, FUNCT_OR, 32'h0F, 32'hF0, exp_t'{SEL_OR, 32'hFF, 1'b0, 1'b0, 2'd0});
    issue(ALUOP_RTYPE, FUNCT_SUB, 32'd10, 32'd3, exp_t'{SEL_SUB, 32'd7, 1'b0, 1'b0, 2'd1});
    issue(ALUOP_ADD, 6'b000000, 32'hFFFFFFFF, 32'd1, exp_t'{SEL_ADD, 32'd0, 1'b1, 1'b0, 2'd2});
    drain();

    // Backpressure: hold the response for 5 cycles, stray request ignored
    rsp_ready = 1'b0;
    issue(ALUOP_ADD, 6'b000000, 32'd2, 32'd2, exp_t'{SEL_ADD, 32'd4, 1'b0, 1'b0, 2'd3});
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        req_valid = 1'b1;
        req_aluop = ALUOP_SUB;
        req_a     = 32'd99;
        req_b     = 32'd1;
      end
      @(posedge clk);
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_result", rsp_result, 32'd4);
      check("bp_zero", 32'(rsp_zero), 32'd0);
      check("bp_err", 32'(rsp_err), 32'd0);
    end
    check("bp_op1_held", alu_op1, 32'd2);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_op1_after", alu_op1, 32'd2);
    drain();

    // Reset during EXEC drops the operation
    @(negedge clk);
    req_valid = 1'b1;
    req_aluop = ALUOP_ADD;
    req_a     = 32'd1;
    req_b     = 32'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("midrst_count_after", 32'(op_count), 32'd0);

    // Counter wrap with CNT_W=2 and 3-cycle issue interval
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      logic [1:0] c;
      c = 2'(i + 1);
      e = exp_t'{SEL_ADD, 32'(i + 10), 1'b0, 1'b0, c};
      issue(ALUOP_ADD, 6'b000000, 32'(i), 32'd10, e);
      if (i > 0) check("issue_interval", 32'(acc_cyc - prev), 32'd3);
      prev = acc_cyc;
    end
    drain();
    check("final_count", 32'(op_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
